// File: rtl/babbage_arbiter.sv
// Two-client round-robin arbiter in front of a single difference-engine
// datapath. Each client may have one request queued; requests are issued
// to the engine one at a time and results are returned with a per-client
// done pulse on the shared out bus.
module babbage_arbiter #(
   parameter int W_IN  = 6,
   parameter int W_OUT = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_a,
   input  logic [W_IN-1:0]  in_a,
   input  logic             start_b,
   input  logic [W_IN-1:0]  in_b,
   output logic             busy_a,
   output logic             busy_b,
   output logic             rej_tick_a,
   output logic             rej_tick_b,
   output logic             done_tick_a,
   output logic             done_tick_b,
   output logic [W_OUT-1:0] out,
   output logic             eng_start,
   output logic [W_IN-1:0]  eng_in,
   input  logic             eng_done_tick,
   input  logic [W_OUT-1:0] eng_out
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   // client encoding for prio/owner: 0 = A, 1 = B
   state_t          state, state_nxt;
   logic            pend_a, pend_b;
   logic [W_IN-1:0] op_a, op_b;
   logic            prio;
   logic            owner, owner_nxt;
   logic            complete;
   logic            acc_a, acc_b;

   // a start is only taken when that client has nothing queued or in service
   assign acc_a      = start_a & ~pend_a;
   assign acc_b      = start_b & ~pend_b;
   assign rej_tick_a = start_a & pend_a;
   assign rej_tick_b = start_b & pend_b;
   assign busy_a     = pend_a;
   assign busy_b     = pend_b;

   // owner's operand is shown to the engine only while it is in service
   assign eng_in = (state != IDLE) ? (owner ? op_b : op_a) : '0;

   // next-state, grant decision and engine start strobe
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      eng_start = 1'b0;
      complete  = 1'b0;
      case (state)
         IDLE: begin
            if (pend_a || pend_b) begin
               // both pending: rotating priority decides; otherwise the lone one
               owner_nxt = (pend_a && pend_b) ? prio : pend_b;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            eng_start = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (eng_done_tick) begin
               complete  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state, ownership and round-robin priority (priority moves only on completion)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         prio  <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         if (complete) prio <= ~owner;
      end
   end

   // per-client request queue: pending flag plus latched operand
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_a <= 1'b0;
         pend_b <= 1'b0;
         op_a   <= '0;
         op_b   <= '0;
      end else begin
         if (acc_a) begin
            pend_a <= 1'b1;
            op_a   <= in_a;
         end else if (complete && !owner) begin
            pend_a <= 1'b0;
         end
         if (acc_b) begin
            pend_b <= 1'b1;
            op_b   <= in_b;
         end else if (complete && owner) begin
            pend_b <= 1'b0;
         end
      end
   end

   // result capture and registered done pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out         <= '0;
         done_tick_a <= 1'b0;
         done_tick_b <= 1'b0;
      end else begin
         done_tick_a <= complete & ~owner;
         done_tick_b <= complete & owner;
         if (complete) out <= eng_out;
      end
   end

endmodule

// File: tb/tb_babbage_arbiter.sv
// Directed bench for babbage_arbiter with a behavioural engine that
// answers f(n) = 2n^2 + 3n + 5, done_tick n+2 cycles after its start.
module tb_babbage_arbiter;

   localparam int W_IN  = 6;
   localparam int W_OUT = 20;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             start_a = 1'b0, start_b = 1'b0;
   logic [W_IN-1:0]  in_a = '0, in_b = '0;
   logic             busy_a, busy_b, rej_tick_a, rej_tick_b;
   logic             done_tick_a, done_tick_b;
   logic [W_OUT-1:0] out;
   logic             eng_start;
   logic [W_IN-1:0]  eng_in;
   logic             eng_done_tick;
   logic [W_OUT-1:0] eng_out;

   babbage_arbiter #(.W_IN(W_IN), .W_OUT(W_OUT)) dut (
      .clk(clk), .reset(reset),
      .start_a(start_a), .in_a(in_a), .start_b(start_b), .in_b(in_b),
      .busy_a(busy_a), .busy_b(busy_b),
      .rej_tick_a(rej_tick_a), .rej_tick_b(rej_tick_b),
      .done_tick_a(done_tick_a), .done_tick_b(done_tick_b),
      .out(out), .eng_start(eng_start), .eng_in(eng_in),
      .eng_done_tick(eng_done_tick), .eng_out(eng_out)
   );

   always #5 clk = ~clk;

   // engine model
   logic             run;
   logic [7:0]       cnt;
   logic [W_OUT-1:0] n_q;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         run <= 1'b0; cnt <= '0; n_q <= '0;
      end else if (eng_start) begin
         run <= 1'b1; cnt <= 8'(eng_in) + 8'd1; n_q <= W_OUT'(eng_in);
      end else if (run) begin
         if (cnt == 0) run <= 1'b0;
         else cnt <= cnt - 8'd1;
      end
   end
   assign eng_done_tick = run && (cnt == 0);
   assign eng_out = eng_done_tick ? W_OUT'(2*n_q*n_q + 3*n_q + 5) : '0;

   // cycle counter and event monitors
   int cyc = 0, n_start = 0, n_da = 0, n_db = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (!reset) begin
         if (eng_start)   n_start++;
         if (done_tick_a) n_da++;
         if (done_tick_b) n_db++;
      end
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic do_reset();
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; in_a = '0; in_b = '0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   // step until the client's done pulse is visible (bounded)
   task automatic wait_done(input bit is_b, input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (is_b ? done_tick_b : done_tick_a) begin found = 1'b1; break; end
      end
      chk({tag, " done seen"}, 32'(found), 32'd1);
   endtask

   int t0, ns, da0, db0, na, nb;
   bit order[$];

   initial begin
      // reset state
      do_reset();
      chk("rst busy_a", 32'(busy_a), 0);
      chk("rst busy_b", 32'(busy_b), 0);
      chk("rst done_a", 32'(done_tick_a), 0);
      chk("rst done_b", 32'(done_tick_b), 0);
      chk("rst out", 32'(out), 0);
      chk("rst eng_start", 32'(eng_start), 0);
      chk("rst eng_in", 32'(eng_in), 0);

      // 1: single request, latency n+5
      start_a = 1'b1; in_a = 6'd3; t0 = cyc; #1;
      chk("t1 rej_a", 32'(rej_tick_a), 0);
      step(); start_a = 1'b0;
      chk("t1 busy_a", 32'(busy_a), 1);
      step();
      chk("t1 eng_start", 32'(eng_start), 1);
      chk("t1 eng_in", 32'(eng_in), 3);
      wait_done(1'b0, "t1");
      chk("t1 latency", 32'(cyc - t0), 8);
      chk("t1 out", 32'(out), 32);
      chk("t1 busy_a after", 32'(busy_a), 0);
      chk("t1 starts", 32'(n_start), 1);
      chk("t1 no done_b", 32'(n_db), 0);

      // 2: simultaneous requests, A first, B two cycles after A completes
      do_reset();
      start_a = 1'b1; in_a = 6'd2; start_b = 1'b1; in_b = 6'd4;
      step(); start_a = 1'b0; start_b = 1'b0;
      step();
      chk("t2 first grant", 32'(eng_in), 2);
      wait_done(1'b0, "t2 a");
      chk("t2 out a", 32'(out), 19);
      step();
      chk("t2 b issue", 32'(eng_start), 1);
      chk("t2 b eng_in", 32'(eng_in), 4);
      wait_done(1'b1, "t2 b");
      chk("t2 out b", 32'(out), 49);

      // 3: fairness under continuous demand, 6 transactions
      do_reset();
      ns = n_start; na = 1; nb = 1; order.delete();
      start_a = 1'b1; in_a = 6'd1; start_b = 1'b1; in_b = 6'd2;
      for (int i = 0; i < 300 && order.size() < 6; i++) begin
         step();
         start_a = 1'b0; start_b = 1'b0;
         if (done_tick_a) begin
            order.push_back(1'b0);
            if (na < 3) begin start_a = 1'b1; na++; end
         end
         if (done_tick_b) begin
            order.push_back(1'b1);
            if (nb < 3) begin start_b = 1'b1; nb++; end
         end
      end
      start_a = 1'b0; start_b = 1'b0;
      chk("t3 count", 32'(order.size()), 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("t3 grant %0d", i), (i < order.size()) ? 32'(order[i]) : 32'd9, 32'(i % 2));
      chk("t3 starts", 32'(n_start - ns), 6);

      // 4: second start while busy is rejected
      do_reset();
      start_a = 1'b1; in_a = 6'd5;
      step(); in_a = 6'd9; #1;
      chk("t4 rej_a", 32'(rej_tick_a), 1);
      step(); start_a = 1'b0;
      wait_done(1'b0, "t4");
      chk("t4 out", 32'(out), 70);

      // 5: operand boundaries and start on own completion cycle
      do_reset();
      start_b = 1'b1; in_b = 6'd0;
      step(); start_b = 1'b0;
      wait_done(1'b1, "t5 zero");
      chk("t5 out zero", 32'(out), 5);
      start_b = 1'b1; in_b = 6'd63;
      step(); start_b = 1'b0;
      for (int i = 0; i < 100 && !eng_done_tick; i++) step();
      chk("t5 completion seen", 32'(eng_done_tick), 1);
      start_b = 1'b1; in_b = 6'd7; #1;
      chk("t5 rej_b", 32'(rej_tick_b), 1);
      step(); start_b = 1'b0;
      chk("t5 done_b", 32'(done_tick_b), 1);
      chk("t5 out max", 32'(out), 8132);
      ns = n_start;
      repeat (10) step();
      chk("t5 no reissue", 32'(n_start - ns), 0);
      chk("t5 busy_b", 32'(busy_b), 0);

      // 6: reset while A is in service and B pending
      do_reset();
      start_a = 1'b1; in_a = 6'd3; start_b = 1'b1; in_b = 6'd4;
      step(); start_a = 1'b0; start_b = 1'b0;
      repeat (3) step();
      chk("t6 pre busy_b", 32'(busy_b), 1);
      reset = 1'b1; #1;
      chk("t6 busy_a", 32'(busy_a), 0);
      chk("t6 busy_b", 32'(busy_b), 0);
      chk("t6 eng_start", 32'(eng_start), 0);
      chk("t6 eng_in", 32'(eng_in), 0);
      chk("t6 out", 32'(out), 0);
      step(); step();
      reset = 1'b0;
      da0 = n_da; db0 = n_db;
      repeat (20) step();
      chk("t6 no done_a", 32'(n_da - da0), 0);
      chk("t6 no done_b", 32'(n_db - db0), 0);
      start_b = 1'b1; in_b = 6'd1;
      step(); start_b = 1'b0;
      wait_done(1'b1, "t6 fresh");
      chk("t6 out fresh", 32'(out), 10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
